// File: rtl/dram_timing_ctrl.sv
// rtl/dram_timing_ctrl.sv - per-bank DRAM timing enforcement and command strobe generation
// Optional feature macro: DRAM_OPEN_ROW_CHK_EN (reject READWRITE to a row other than the open one)
module dram_timing_ctrl #(
  parameter int NUM_OF_BANKS = 8,
  parameter int NUM_OF_ROWS  = 128,
  parameter int NUM_OF_COLS  = 8,
  parameter int T_RCD        = 3,
  parameter int T_RP         = 3,
  parameter int T_RAS        = 6,
  parameter int T_RFC        = 10,
  parameter int BURST_LEN    = 8
) (
  input  logic                            clk,
  input  logic                            rst_b,
  input  logic                            cmd_req,
  input  logic [1:0]                      cmd,
  input  logic [NUM_OF_BANKS-1:0]         bank_sel,
  input  logic [NUM_OF_ROWS-1:0]          row_sel,
  input  logic [NUM_OF_COLS-1:0]          col_sel,
  input  logic                            bank_rw,
  output logic                            cmd_ack,
  output logic                            cmd_err,
  output logic                            dram_act,
  output logic                            dram_pre,
  output logic                            dram_rd,
  output logic                            dram_wr,
  output logic                            dram_ref,
  output logic [$clog2(NUM_OF_BANKS)-1:0] dram_bank,
  output logic [$clog2(NUM_OF_ROWS)-1:0]  dram_row,
  output logic [$clog2(NUM_OF_COLS)-1:0]  dram_col,
  output logic                            burst_active,
  output logic [NUM_OF_BANKS-1:0]         banks_open
);

  localparam int BANK_W = $clog2(NUM_OF_BANKS);
  localparam int ROW_W  = $clog2(NUM_OF_ROWS);
  localparam int COL_W  = $clog2(NUM_OF_COLS);
  localparam int RAS_W  = $clog2(T_RAS + 1);
  localparam int RP_W   = $clog2(T_RP + 1);
  localparam int DLY_A  = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int DLY_B  = (T_RFC > BURST_LEN) ? T_RFC : BURST_LEN;
  localparam int DLY_MAX = (DLY_A > DLY_B) ? DLY_A : DLY_B;
  localparam int DLY_W  = $clog2(DLY_MAX + 1);
  localparam int ENC_AB = (NUM_OF_BANKS > NUM_OF_ROWS) ? NUM_OF_BANKS : NUM_OF_ROWS;
  localparam int ENC_W  = (ENC_AB > NUM_OF_COLS) ? ENC_AB : NUM_OF_COLS;

  localparam logic [1:0] CMD_REF = 2'b00;
  localparam logic [1:0] CMD_ACT = 2'b01;
  localparam logic [1:0] CMD_RW  = 2'b10;
  localparam logic [1:0] CMD_PRE = 2'b11;

  typedef enum logic [1:0] {IDLE, CHECK, DELAY, DONE} state_t;

  state_t              state;
  logic [1:0]          cmd_q;
  logic [BANK_W-1:0]   bank_q;
  logic [ROW_W-1:0]    row_q;
  logic [COL_W-1:0]    col_q;
  logic                rw_q;
  logic                bank_ok_q;
  logic                row_ok_q;
  logic                col_ok_q;
  logic                err_q;
  logic [DLY_W-1:0]    dly_cnt;
  logic [RAS_W-1:0]    ras_cnt [NUM_OF_BANKS];
  logic [RP_W-1:0]     rp_cnt  [NUM_OF_BANKS];
`ifdef DRAM_OPEN_ROW_CHK_EN
  logic [ROW_W-1:0]    open_row [NUM_OF_BANKS];
`endif

  logic                all_rp_zero;
  logic                illegal;
  logic                timing_met;
  logic [DLY_W-1:0]    dly_load;
  logic                reject;
  logic                issue;

  // One-hot to binary; only meaningful when the input is exactly one-hot.
  function automatic int onehot_enc(input logic [ENC_W-1:0] v);
    int r;
    r = 0;
    for (int i = 0; i < ENC_W; i++) begin
      if (v[i]) r = r | i;
    end
    return r;
  endfunction

  // Refresh may only start once every bank has finished its precharge time.
  always_comb begin
    all_rp_zero = 1'b1;
    for (int b = 0; b < NUM_OF_BANKS; b++) begin
      if (rp_cnt[b] != '0) all_rp_zero = 1'b0;
    end
  end

  // Legality, timing readiness and delay selection for the latched command.
  always_comb begin
    illegal    = 1'b0;
    timing_met = 1'b0;
    dly_load   = '0;
    if (!bank_ok_q) begin
      illegal = 1'b1;
    end else begin
      case (cmd_q)
        CMD_ACT: begin
          illegal    = !row_ok_q || banks_open[bank_q];
          timing_met = (rp_cnt[bank_q] == '0);
          dly_load   = DLY_W'(T_RCD);
        end
        CMD_RW: begin
          illegal    = !col_ok_q || !banks_open[bank_q];
`ifdef DRAM_OPEN_ROW_CHK_EN
          if (!row_ok_q || (open_row[bank_q] != row_q)) illegal = 1'b1;
`endif
          timing_met = 1'b1;
          dly_load   = DLY_W'(BURST_LEN);
        end
        CMD_PRE: begin
          illegal    = !banks_open[bank_q];
          timing_met = (ras_cnt[bank_q] == '0);
          dly_load   = DLY_W'(T_RP);
        end
        default: begin
          illegal    = |banks_open;
          timing_met = all_rp_zero;
          dly_load   = DLY_W'(T_RFC);
        end
      endcase
    end
    reject = (state == CHECK) && illegal;
    issue  = (state == CHECK) && !illegal && timing_met;
  end

  // Per-bank tRAS / tRP down-counters, loaded on issue and saturating at zero.
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      for (int b = 0; b < NUM_OF_BANKS; b++) begin
        ras_cnt[b] <= '0;
        rp_cnt[b]  <= '0;
      end
    end else begin
      for (int b = 0; b < NUM_OF_BANKS; b++) begin
        if (issue && (cmd_q == CMD_ACT) && (bank_q == BANK_W'(b)))
          ras_cnt[b] <= RAS_W'(T_RAS);
        else if (ras_cnt[b] != '0)
          ras_cnt[b] <= ras_cnt[b] - 1'b1;
        if (issue && (cmd_q == CMD_PRE) && (bank_q == BANK_W'(b)))
          rp_cnt[b] <= RP_W'(T_RP);
        else if (rp_cnt[b] != '0)
          rp_cnt[b] <= rp_cnt[b] - 1'b1;
      end
    end
  end

  // Command FSM with registered strobes, ack/err and bank open state.
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state        <= IDLE;
      cmd_q        <= CMD_REF;
      bank_q       <= '0;
      row_q        <= '0;
      col_q        <= '0;
      rw_q         <= 1'b0;
      bank_ok_q    <= 1'b0;
      row_ok_q     <= 1'b0;
      col_ok_q     <= 1'b0;
      err_q        <= 1'b0;
      dly_cnt      <= '0;
      cmd_ack      <= 1'b0;
      cmd_err      <= 1'b0;
      dram_act     <= 1'b0;
      dram_pre     <= 1'b0;
      dram_rd      <= 1'b0;
      dram_wr      <= 1'b0;
      dram_ref     <= 1'b0;
      dram_bank    <= '0;
      dram_row     <= '0;
      dram_col     <= '0;
      burst_active <= 1'b0;
      banks_open   <= '0;
`ifdef DRAM_OPEN_ROW_CHK_EN
      for (int b = 0; b < NUM_OF_BANKS; b++) open_row[b] <= '0;
`endif
    end else begin
      cmd_ack  <= 1'b0;
      cmd_err  <= 1'b0;
      dram_act <= 1'b0;
      dram_pre <= 1'b0;
      dram_rd  <= 1'b0;
      dram_wr  <= 1'b0;
      dram_ref <= 1'b0;
      case (state)
        IDLE: begin
          // cmd_ack is still high in the first IDLE cycle while the requester
          // releases cmd_req, so that cycle must not start a new command.
          if (cmd_req && !cmd_ack) begin
            cmd_q     <= cmd;
            bank_q    <= BANK_W'(onehot_enc(ENC_W'(bank_sel)));
            row_q     <= ROW_W'(onehot_enc(ENC_W'(row_sel)));
            col_q     <= COL_W'(onehot_enc(ENC_W'(col_sel)));
            rw_q      <= bank_rw;
            bank_ok_q <= $onehot(bank_sel);
            row_ok_q  <= $onehot(row_sel);
            col_ok_q  <= $onehot(col_sel);
            state     <= CHECK;
          end
        end
        CHECK: begin
          if (reject) begin
            err_q <= 1'b1;
            state <= DONE;
          end else if (issue) begin
            dram_bank <= bank_q;
            dly_cnt   <= dly_load;
            state     <= DELAY;
            case (cmd_q)
              CMD_ACT: begin
                dram_act           <= 1'b1;
                dram_row           <= row_q;
                banks_open[bank_q] <= 1'b1;
`ifdef DRAM_OPEN_ROW_CHK_EN
                open_row[bank_q]   <= row_q;
`endif
              end
              CMD_RW: begin
                dram_rd      <= !rw_q;
                dram_wr      <= rw_q;
                dram_col     <= col_q;
                burst_active <= 1'b1;
              end
              CMD_PRE: begin
                dram_pre           <= 1'b1;
                banks_open[bank_q] <= 1'b0;
              end
              default: dram_ref <= 1'b1;
            endcase
          end
        end
        DELAY: begin
          dly_cnt <= dly_cnt - 1'b1;
          if (dly_cnt <= DLY_W'(2)) state <= DONE;
        end
        DONE: begin
          cmd_ack      <= 1'b1;
          cmd_err      <= err_q;
          err_q        <= 1'b0;
          burst_active <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_timing_ctrl.sv
// tb/tb_dram_timing_ctrl.sv - scoreboard bench for dram_timing_ctrl
module tb_dram_timing_ctrl;

  localparam int NB = 8, NR = 128, NC = 8;
  localparam int T_RCD = 3, T_RP = 3, T_RAS = 6, T_RFC = 10, BL = 8;

  logic          clk = 1'b0;
  logic          rst_b = 1'b0;
  logic          cmd_req = 1'b0;
  logic [1:0]    cmd = '0;
  logic [NB-1:0] bank_sel = '0;
  logic [NR-1:0] row_sel = '0;
  logic [NC-1:0] col_sel = '0;
  logic          bank_rw = 1'b0;
  logic          cmd_ack, cmd_err, dram_act, dram_pre, dram_rd, dram_wr, dram_ref;
  logic [2:0]    dram_bank;
  logic [6:0]    dram_row;
  logic [2:0]    dram_col;
  logic          burst_active;
  logic [NB-1:0] banks_open;

  dram_timing_ctrl #(
    .NUM_OF_BANKS(NB), .NUM_OF_ROWS(NR), .NUM_OF_COLS(NC),
    .T_RCD(T_RCD), .T_RP(T_RP), .T_RAS(T_RAS), .T_RFC(T_RFC), .BURST_LEN(BL)
  ) dut (
    .clk(clk), .rst_b(rst_b), .cmd_req(cmd_req), .cmd(cmd),
    .bank_sel(bank_sel), .row_sel(row_sel), .col_sel(col_sel), .bank_rw(bank_rw),
    .cmd_ack(cmd_ack), .cmd_err(cmd_err),
    .dram_act(dram_act), .dram_pre(dram_pre), .dram_rd(dram_rd), .dram_wr(dram_wr),
    .dram_ref(dram_ref), .dram_bank(dram_bank), .dram_row(dram_row), .dram_col(dram_col),
    .burst_active(burst_active), .banks_open(banks_open)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {int kind; int bank; int row; int col; int t;} sexp_t;
  typedef struct {int err; int t;} aexp_t;
  sexp_t sq[$];
  aexp_t aq[$];

  bit mdl_open [NB];
  int mdl_row  [NB];
  int t_act    [NB];
  int t_pre    [NB];

  task automatic check_eq(input string tag, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic int oh_idx(input logic [127:0] v);
    int r;
    r = 0;
    for (int i = 0; i < 128; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin
      mdl_open[b] = 1'b0;
      mdl_row[b]  = 0;
      t_act[b]    = -1000;
      t_pre[b]    = -1000;
    end
  endtask

  // Monitor: strobes and acks are popped from the scoreboard as they appear.
  int bcnt = 0;
  always @(negedge clk) begin : mon
    logic [4:0] s;
    sexp_t e;
    aexp_t a;
    int k;
    if (rst_b) begin
      bcnt = 0;
    end else begin
      s = {dram_ref, dram_wr, dram_rd, dram_pre, dram_act};
      if (s != 5'b0) begin
        check_eq("strb_count", $countones(s), 1);
        k = 0;
        for (int i = 0; i < 5; i++) if (s[i]) k = i;
        if (sq.size() == 0) begin
          check_eq("strb_unexpected", k, -1);
        end else begin
          e = sq.pop_front();
          check_eq("strb_kind", k, e.kind);
          check_eq("strb_bank", int'(dram_bank), e.bank);
          check_eq("strb_cycle", cyc, e.t);
          if (k == 0) check_eq("strb_row", int'(dram_row), e.row);
          if (k == 2 || k == 3) check_eq("strb_col", int'(dram_col), e.col);
        end
      end
      if (cmd_ack) begin
        if (aq.size() == 0) begin
          check_eq("ack_unexpected", 1, 0);
        end else begin
          a = aq.pop_front();
          check_eq("ack_err", int'(cmd_err), a.err);
          check_eq("ack_cycle", cyc, a.t);
        end
      end else if (cmd_err) begin
        check_eq("err_without_ack", 1, 0);
      end
      if (burst_active) bcnt++;
      else if (bcnt != 0) begin
        check_eq("burst_len", bcnt, BL);
        bcnt = 0;
      end
    end
  end

  // Drive one command, pushing the model's expected strobe and ack first.
  task automatic cmd_go(input int c, input logic [NB-1:0] bs, input logic [NR-1:0] rs,
                        input logic [NC-1:0] cs, input logic rw);
    int acc, b, r, col, s, err, dly, n;
    sexp_t e;
    aexp_t a;
    @(posedge clk);
    #1;
    acc = cyc + 1;
    b   = oh_idx(128'(bs));
    r   = oh_idx(rs);
    col = oh_idx(128'(cs));
    err = 0;
    dly = 0;
    if (!$onehot(bs)) err = 1;
    else begin
      case (c)
        1: if (!$onehot(rs) || mdl_open[b]) err = 1;
        2: begin
          if (!$onehot(cs) || !mdl_open[b]) err = 1;
`ifdef DRAM_OPEN_ROW_CHK_EN
          if (!$onehot(rs) || r != mdl_row[b]) err = 1;
`endif
        end
        3: if (!mdl_open[b]) err = 1;
        default: for (int i = 0; i < NB; i++) if (mdl_open[i]) err = 1;
      endcase
    end
    if (err != 0) begin
      a.err = 1;
      a.t   = acc + 2;
      aq.push_back(a);
    end else begin
      s = acc + 1;
      case (c)
        1: begin
          if (t_pre[b] + T_RP + 1 > s) s = t_pre[b] + T_RP + 1;
          e.kind = 0; dly = T_RCD;
          mdl_open[b] = 1'b1; mdl_row[b] = r; t_act[b] = s;
        end
        2: begin
          e.kind = rw ? 3 : 2; dly = BL;
        end
        3: begin
          if (t_act[b] + T_RAS + 1 > s) s = t_act[b] + T_RAS + 1;
          e.kind = 1; dly = T_RP;
          mdl_open[b] = 1'b0; t_pre[b] = s;
        end
        default: begin
          for (int i = 0; i < NB; i++) if (t_pre[i] + T_RP + 1 > s) s = t_pre[i] + T_RP + 1;
          e.kind = 4; dly = T_RFC;
        end
      endcase
      e.bank = b; e.row = r; e.col = col; e.t = s;
      sq.push_back(e);
      a.err = 0;
      a.t   = s + dly;
      aq.push_back(a);
    end
    cmd = 2'(c); bank_sel = bs; row_sel = rs; col_sel = cs; bank_rw = rw;
    cmd_req = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ack && n < 300);
    cmd_req = 1'b0;
    if (!cmd_ack) begin
      check_eq("ack_timeout", 0, 1);
      sq.delete();
      aq.delete();
    end
  endtask

  initial begin : main
    sexp_t e;
    int c, b, rr;
    logic [NB-1:0] bs;
    logic [NR-1:0] rs;
    logic [NC-1:0] cs;
    model_reset();

    #1 rst_b = 1'b1;
    #2;
    check_eq("rst_flags", int'({cmd_ack, cmd_err, dram_act, dram_pre, dram_rd, dram_wr, dram_ref, burst_active}), 0);
    check_eq("rst_bank", int'(dram_bank), 0);
    check_eq("rst_row", int'(dram_row), 0);
    check_eq("rst_col", int'(dram_col), 0);
    check_eq("rst_open", int'(banks_open), 0);
    repeat (3) @(posedge clk);
    #1 rst_b = 1'b0;

    // Reset in the middle of an ACT's delay: no ack may follow.
    @(posedge clk);
    #1;
    cmd = 2'b01; bank_sel = 8'h02; row_sel = 128'(1) << 9; col_sel = 8'h01; bank_rw = 1'b0;
    cmd_req = 1'b1;
    e.kind = 0; e.bank = 1; e.row = 9; e.col = 0; e.t = cyc + 2;
    sq.push_back(e);
    @(posedge clk);
    #1 cmd_req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_b = 1'b1;
    #1;
    check_eq("midrst_flags", int'({cmd_ack, cmd_err, dram_act, dram_pre, dram_rd, dram_wr, dram_ref, burst_active}), 0);
    check_eq("midrst_bank", int'(dram_bank), 0);
    check_eq("midrst_row", int'(dram_row), 0);
    check_eq("midrst_open", int'(banks_open), 0);
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_b = 1'b0;

    cmd_go(1, 8'h04, 128'(1) << 1, 8'h01, 1'b0);
    check_eq("open_b2", int'(banks_open), 32'h04);
    cmd_go(1, 8'h08, 128'(1) << 5, 8'h01, 1'b0);
    check_eq("open_b23", int'(banks_open), 32'h0C);
    cmd_go(3, 8'h08, 128'(1) << 5, 8'h01, 1'b0);
    check_eq("open_after_pre", int'(banks_open), 32'h04);
    cmd_go(1, 8'h08, 128'(1) << 5, 8'h01, 1'b0);
    cmd_go(2, 8'h08, 128'(1) << 5, 8'h40, 1'b0);
    cmd_go(2, 8'h08, 128'(1) << 5, 8'h02, 1'b1);
    cmd_go(0, 8'h01, 128'(1), 8'h01, 1'b0);
    cmd_go(3, 8'h04, 128'(1), 8'h01, 1'b0);
    cmd_go(3, 8'h08, 128'(1), 8'h01, 1'b0);
    check_eq("open_none", int'(banks_open), 0);
    cmd_go(0, 8'h01, 128'(1), 8'h01, 1'b0);
    cmd_go(1, 8'h0C, 128'(1) << 2, 8'h01, 1'b0);
    cmd_go(1, 8'h00, 128'(1) << 2, 8'h01, 1'b0);
    cmd_go(2, 8'h20, 128'(1) << 2, 8'h01, 1'b0);
    cmd_go(1, 8'h08, 128'(1) << 5, 8'h01, 1'b0);
    cmd_go(1, 8'h08, 128'(1) << 5, 8'h01, 1'b0);
    cmd_go(2, 8'h08, 128'(1) << 6, 8'h04, 1'b0);
    cmd_go(2, 8'h08, 128'(1) << 5, 8'h03, 1'b0);
    cmd_go(1, 8'h10, 128'(0), 8'h01, 1'b0);

    for (int i = 0; i < 40; i++) begin
      c  = $urandom_range(0, 3);
      b  = $urandom_range(0, 3);
      rr = $urandom_range(0, 127);
      bs = 8'(1) << b;
      if ($urandom_range(0, 7) == 0) bs = 8'($urandom);
      rs = 128'(1) << rr;
      if (c == 2 && $urandom_range(0, 1) == 1) rs = 128'(1) << mdl_row[b];
      cs = 8'(1) << $urandom_range(0, 7);
      cmd_go(c, bs, rs, cs, 1'($urandom_range(0, 1)));
    end

    repeat (12) @(posedge clk);
    check_eq("scoreboard_empty", sq.size() + aq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
